// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network readout blocks: classifier
// FSM state encoding and default network dimensions.
package snn_pkg;

    localparam int N_OUT_DEFAULT   = 10;
    localparam int T_STEPS_DEFAULT = 25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } cls_state_t;

endpackage

// File: rtl/spk_count_bank.sv
// Per-class saturating spike counters: synchronous clear, parallel
// increment from a spike vector, and a combinational indexed read port.
module spk_count_bank #(
    parameter int N     = 10,
    parameter int W     = 5,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc_en,
    input  logic [N-1:0]     inc_vec,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [W-1:0]     rd_cnt
);

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = W'(1);

    logic [W-1:0] cnt_q [N];
    logic [W-1:0] cnt_d [N];

    // Next counter values: clear wins, otherwise count each set bit and stop at the maximum.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = CNT_ZERO;
            end else if (inc_en && inc_vec[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Counter storage with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Indexed read; out-of-range indices return zero.
    always_comb begin
        rd_cnt = CNT_ZERO;
        if (int'(rd_idx) < N) begin
            rd_cnt = cnt_q[rd_idx];
        end else begin
            rd_cnt = CNT_ZERO;
        end
    end

endmodule

// File: rtl/spk_argmax_classifier.sv
// Argmax readout for a spiking output layer: integrates class spikes over
// T_STEPS timesteps, scans the counters one per cycle for the maximum
// (ties go to the lowest index) and holds the result until acknowledged.
module spk_argmax_classifier
    import snn_pkg::*;
#(
    parameter int N_OUT   = N_OUT_DEFAULT,
    parameter int T_STEPS = T_STEPS_DEFAULT,
    parameter int CNT_W   = $clog2(T_STEPS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     step_valid,
    input  logic [N_OUT-1:0]         spikes_in_bits,
    input  logic                     res_ack,
    output logic                     busy,
    output logic                     res_valid,
    output logic [$clog2(N_OUT)-1:0] res_class,
    output logic [CNT_W-1:0]         res_count
);

    localparam int IDX_W  = $clog2(N_OUT);
    localparam int STEP_W = $clog2(T_STEPS + 1);

    localparam logic [STEP_W-1:0] STEP_ZERO    = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_ONE     = STEP_W'(1);
    localparam logic [STEP_W-1:0] LAST_STEP_M1 = STEP_W'(T_STEPS - 1);
    localparam logic [IDX_W-1:0]  IDX_ZERO     = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE      = IDX_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(N_OUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO     = {CNT_W{1'b0}};

    cls_state_t        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic [CNT_W-1:0]  best_cnt_q, best_cnt_d;
    logic              res_valid_q, res_valid_d;
    logic [IDX_W-1:0]  res_class_q, res_class_d;
    logic [CNT_W-1:0]  res_count_q, res_count_d;

    logic              bank_clr;
    logic              bank_inc;
    logic [CNT_W-1:0]  rd_cnt;

    spk_count_bank #(
        .N     (N_OUT),
        .W     (CNT_W),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .clr     (bank_clr),
        .inc_en  (bank_inc),
        .inc_vec (spikes_in_bits),
        .rd_idx  (scan_idx_q),
        .rd_cnt  (rd_cnt)
    );

    // State and datapath registers; reset aborts any inference in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= STEP_ZERO;
            scan_idx_q  <= IDX_ZERO;
            best_idx_q  <= IDX_ZERO;
            best_cnt_q  <= CNT_ZERO;
            res_valid_q <= 1'b0;
            res_class_q <= IDX_ZERO;
            res_count_q <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            scan_idx_q  <= scan_idx_d;
            best_idx_q  <= best_idx_d;
            best_cnt_q  <= best_cnt_d;
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
            res_count_q <= res_count_d;
        end
    end

    // Next-state logic. The ack is only taken once the result is visible.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ACCUM;
                else       state_d = ST_IDLE;
            end
            ST_ACCUM: begin
                if (step_valid && (step_q == LAST_STEP_M1)) state_d = ST_SCAN;
                else                                         state_d = ST_ACCUM;
            end
            ST_SCAN: begin
                if (scan_idx_q == LAST_IDX) state_d = ST_DONE;
                else                        state_d = ST_SCAN;
            end
            ST_DONE: begin
                if (res_ack && res_valid_q) state_d = ST_IDLE;
                else                        state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output logic: clear on start, accumulate steps, scan for
    // the strict maximum, then publish the result one cycle into DONE.
    always_comb begin
        step_d      = step_q;
        scan_idx_d  = scan_idx_q;
        best_idx_d  = best_idx_q;
        best_cnt_d  = best_cnt_q;
        res_valid_d = res_valid_q;
        res_class_d = res_class_q;
        res_count_d = res_count_q;
        bank_clr    = 1'b0;
        bank_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                res_valid_d = 1'b0;
                if (start) begin
                    bank_clr   = 1'b1;
                    step_d     = STEP_ZERO;
                    scan_idx_d = IDX_ZERO;
                    best_idx_d = IDX_ZERO;
                    best_cnt_d = CNT_ZERO;
                end else begin
                    bank_clr = 1'b0;
                end
            end
            ST_ACCUM: begin
                res_valid_d = 1'b0;
                if (step_valid) begin
                    bank_inc = 1'b1;
                    step_d   = step_q + STEP_ONE;
                end else begin
                    bank_inc = 1'b0;
                end
            end
            ST_SCAN: begin
                if (rd_cnt > best_cnt_q) begin
                    best_idx_d = scan_idx_q;
                    best_cnt_d = rd_cnt;
                end else begin
                    best_idx_d = best_idx_q;
                end
                if (scan_idx_q != LAST_IDX) scan_idx_d = scan_idx_q + IDX_ONE;
                else                        scan_idx_d = scan_idx_q;
            end
            ST_DONE: begin
                if (!res_valid_q) begin
                    res_valid_d = 1'b1;
                    res_class_d = best_idx_q;
                    res_count_d = best_cnt_q;
                end else if (res_ack) begin
                    res_valid_d = 1'b0;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                res_valid_d = 1'b0;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign res_valid = res_valid_q;
    assign res_class = res_class_q;
    assign res_count = res_count_q;

endmodule

// File: tb/tb_spk_argmax_classifier.sv
// Scoreboard bench for spk_argmax_classifier: the driver pushes hand-computed
// results, a negedge monitor pops and compares each presented result.
module tb_spk_argmax_classifier;

    localparam int N  = 10;
    localparam int T  = 25;
    localparam int CW = 5;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          step_valid;
    logic [N-1:0]  spikes_in_bits;
    logic          res_ack;
    logic          busy;
    logic          res_valid;
    logic [IW-1:0] res_class;
    logic [CW-1:0] res_count;

    spk_argmax_classifier #(.N_OUT(N), .T_STEPS(T), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .step_valid     (step_valid),
        .spikes_in_bits (spikes_in_bits),
        .res_ack        (res_ack),
        .busy           (busy),
        .res_valid      (res_valid),
        .res_class      (res_class),
        .res_count      (res_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cls;
        int cnt;
        int edge_at;
    } exp_t;

    exp_t         sb_q[$];
    int           errors = 0;
    int           checks = 0;
    logic [N-1:0] vec_tab[T];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop one expectation per presented result, then check it every valid cycle.
    exp_t cur;
    bit   seen = 1'b0;
    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                    cur = '{0, 0, 0};
                end else begin
                    cur = sb_q.pop_front();
                    chk("valid_latency_edge", cyc, cur.edge_at);
                end
            end
            chk("res_class", int'(res_class), cur.cls);
            chk("res_count", int'(res_count), cur.cnt);
        end else begin
            seen = 1'b0;
        end
    end

    // One full inference from the current vec_tab; inject exercises ignored start/step pulses.
    task automatic run_inf(input int cls, input int cnt, input bit inject, input int ack_delay);
        int w;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_accum", int'(busy), 1);
        for (int i = 0; i < T; i++) begin
            spikes_in_bits = vec_tab[i];
            step_valid     = 1'b1;
            if (inject && (i == 5)) start = 1'b1;
            if (i == T - 1) sb_q.push_back('{cls, cnt, cyc + N + 2});
            @(negedge clk);
            step_valid     = 1'b0;
            start          = 1'b0;
            spikes_in_bits = '0;
            if ((i % 4) == 3) @(negedge clk);
        end
        w = 0;
        while ((res_valid !== 1'b1) && (w < 100)) begin
            if (inject) begin
                start          = w[0];
                step_valid     = 1'b1;
                spikes_in_bits = '1;
            end
            @(negedge clk);
            start          = 1'b0;
            step_valid     = 1'b0;
            spikes_in_bits = '0;
            w++;
        end
        if (res_valid !== 1'b1) begin
            chk("result_timeout", 0, 1);
            return;
        end
        for (int k = 0; k < ack_delay; k++) begin
            if (inject) begin
                step_valid     = 1'b1;
                spikes_in_bits = '1;
            end
            @(negedge clk);
            step_valid     = 1'b0;
            spikes_in_bits = '0;
        end
        chk("valid_before_ack", int'(res_valid), 1);
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        chk("busy_after_ack", int'(busy), 0);
        chk("valid_after_ack", int'(res_valid), 0);
        chk("class_retained", int'(res_class), cls);
        chk("count_retained", int'(res_count), cnt);
    endtask

    task automatic load_class3();
        for (int i = 0; i < T; i++) vec_tab[i] = N'(1) << 3;
    endtask

    initial begin
        logic [N-1:0] v;
        rst = 1'b1; start = 1'b0; step_valid = 1'b0; res_ack = 1'b0; spikes_in_bits = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(res_valid), 0);
        chk("reset_class", int'(res_class), 0);
        chk("reset_count", int'(res_count), 0);
        rst = 1'b0;

        // A: only class 3 spikes, every step.
        load_class3();
        run_inf(3, 25, 1'b0, 2);

        // B: classes 2 and 7 tie at 12, class 0 has 10, class 5 has 11, class 9 has 5.
        for (int i = 0; i < T; i++) begin
            v = '0;
            if (i < 12) begin v[2] = 1'b1; v[7] = 1'b1; end
            if (i < 11) v[5] = 1'b1;
            if (i < 10) v[0] = 1'b1;
            if (i >= 20) v[9] = 1'b1;
            vec_tab[i] = v;
        end
        run_inf(2, 12, 1'b0, 1);

        // C: no spikes at all.
        for (int i = 0; i < T; i++) vec_tab[i] = '0;
        run_inf(0, 0, 1'b0, 0);

        // D: scenario A with stray start/step pulses in ACCUM, SCAN and DONE.
        load_class3();
        run_inf(3, 25, 1'b1, 3);

        // E: abort after 10 all-ones steps, then a fresh scenario A.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            spikes_in_bits = '1;
            step_valid     = 1'b1;
            @(negedge clk);
        end
        step_valid = 1'b0; spikes_in_bits = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(res_valid), 0);
        chk("abort_class", int'(res_class), 0);
        chk("abort_count", int'(res_count), 0);
        rst = 1'b0;
        run_inf(3, 25, 1'b0, 0);

        // F: result held for 50 cycles before acknowledgement.
        run_inf(3, 25, 1'b0, 50);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
